// File: rtl/split_arbiter_pkg.sv
// Shared encodings for the split-capable bus arbiter and the slaves that talk to it.
// HRESP codes and the arbiter state encoding live here so slaves decode them identically.
package split_arbiter_pkg;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_OWN   = 2'd2
  } arb_state_e;

  localparam int unsigned NumMasters = 4;
  localparam int unsigned TenureW    = 8;

  function automatic logic [NumMasters-1:0] master_oh(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/split_arbiter_rr_pick4.sv
// Four-way round-robin picker: first eligible master searching upward from ptr+1 (mod 4).
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] idx;

  // Walk from the farthest offset back to the nearest so the nearest hit is kept.
  always_comb begin
    winner = ptr;
    any    = 1'b0;
    idx    = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (eligible[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/split_arbiter.sv
// Four-master round-robin bus arbiter with locked tenures and SPLIT parking.
// Define ARB_TENURE_LIMIT_EN to build the tenure counter that forces re-arbitration.
module split_arbiter
  import split_arbiter_pkg::*;
#(
  parameter int unsigned MAX_TENURE     = 16,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [3:0] LOCK,
  input  logic       HREADY,
  input  logic [1:0] HRESP,
  input  logic [1:0] HSPLIT,
  input  logic       HSPLIT_VLD,
  output logic [3:0] GNT,
  output logic [1:0] HMAS,
  output logic       MLOCK,
  output logic [3:0] SPLIT_MASK,
  output logic       BUS_IDLE
);

  if (MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_bad_tenure
    $fatal(1, "MAX_TENURE must be in 2..255");
  end

  arb_state_e state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] hmas_q, hmas_d;
  logic       mlock_q, mlock_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;

  logic [3:0] eligible;
  logic [1:0] pick_winner;
  logic       pick_any;
  logic       split_hit;
  logic       own_lock;
  logic       own_req;
  logic       expire;

  assign eligible  = REQ & ~mask_q;
  assign split_hit = (state_q == ARB_OWN) && (HRESP == HRESP_SPLIT);
  assign own_lock  = LOCK[hmas_q];
  assign own_req   = REQ[hmas_q];

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .winner   (pick_winner),
    .any      (pick_any)
  );

`ifdef ARB_TENURE_LIMIT_EN
  localparam logic [TenureW-1:0] TenureLast = TenureW'(MAX_TENURE - 1);

  logic [TenureW-1:0] tenure_q, tenure_d;

  assign expire = (tenure_q == TenureLast) && (|(eligible & ~master_oh(hmas_q)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tenure_q <= '0;
    else     tenure_q <= tenure_d;
  end

  // Saturates so a lone owner does not wrap and miss the limit later.
  always_comb begin
    tenure_d = tenure_q;
    if (state_q == ARB_GRANT && HREADY) begin
      tenure_d = '0;
    end else if (state_q == ARB_OWN && !split_hit && HREADY) begin
      if (own_lock)                    tenure_d = '0;
      else if (tenure_q != TenureLast) tenure_d = tenure_q + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      hmas_q   <= 2'(DEFAULT_MASTER);
      mlock_q  <= 1'b0;
      mask_q   <= '0;
      rr_ptr_q <= 2'(DEFAULT_MASTER);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      hmas_q   <= hmas_d;
      mlock_q  <= mlock_d;
      mask_q   <= mask_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_GRANT;
      ARB_GRANT: if (HREADY) state_d = ARB_OWN;
      ARB_OWN: begin
        if (split_hit) state_d = ARB_IDLE;
        else if (HREADY && !own_lock && (!own_req || expire)) state_d = ARB_IDLE;
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    hmas_d   = hmas_q;
    mlock_d  = mlock_q;
    rr_ptr_d = rr_ptr_q;
    mask_d   = mask_q;
    // Clear first so a same-bit SPLIT set below wins.
    if (HSPLIT_VLD) mask_d[HSPLIT] = 1'b0;
    if (split_hit)  mask_d[hmas_q] = 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          gnt_d    = master_oh(pick_winner);
          hmas_d   = pick_winner;
          rr_ptr_d = pick_winner;
        end
      end
      ARB_GRANT: if (HREADY) mlock_d = own_lock;
      ARB_OWN: begin
        if (split_hit) begin
          gnt_d   = '0;
          mlock_d = 1'b0;
        end else if (HREADY) begin
          mlock_d = own_lock;
          if (!own_lock && (!own_req || expire)) gnt_d = '0;
        end
      end
      default: begin
        gnt_d   = '0;
        mlock_d = 1'b0;
      end
    endcase
  end

  assign GNT        = gnt_q;
  assign HMAS       = hmas_q;
  assign MLOCK      = mlock_q;
  assign SPLIT_MASK = mask_q;
  assign BUS_IDLE   = (state_q == ARB_IDLE);

endmodule
